// File: rtl/game_timer_ctrl.sv
// Elapsed-game-time controller: 1 ms prescaler plus cascaded H:MM:SS.ddd counter with start/stop/clear.
// Optional build macro TIMER_VBLANK_SYNC_EN adds a vblank input and shadow registers on the time_* outputs.
module game_timer_ctrl #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int MAX_HOURS   = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
`ifdef TIMER_VBLANK_SYNC_EN
  input  logic       vblank,
`endif
  output logic [4:0] time_hours,
  output logic [5:0] time_minutes,
  output logic [5:0] time_seconds,
  output logic [3:0] time_deciseconds,
  output logic [3:0] time_centiseconds,
  output logic [3:0] time_milliseconds,
  output logic       running,
  output logic       overflow
);

  localparam int TICKS_PER_MS = CLK_FREQ_HZ / 1000;
  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_MS - 1);
  localparam logic [4:0] MAX_H = 5'(MAX_HOURS);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, SATURATED} state_t;

  state_t        state, state_next;
  logic [PW-1:0] presc, presc_next;
  logic [4:0]    hours_q, hours_next;
  logic [5:0]    minutes_q, minutes_next;
  logic [5:0]    seconds_q, seconds_next;
  logic [3:0]    ds_q, ds_next;
  logic [3:0]    cs_q, cs_next;
  logic [3:0]    ms_q, ms_next;
  logic          tick;
  logic          at_max;

  always_comb begin
    state_next   = state;
    presc_next   = presc;
    hours_next   = hours_q;
    minutes_next = minutes_q;
    seconds_next = seconds_q;
    ds_next      = ds_q;
    cs_next      = cs_q;
    ms_next      = ms_q;
    tick   = (state == RUNNING) && (presc == PRESC_MAX);
    at_max = (hours_q == MAX_H) && (minutes_q == 6'd59) && (seconds_q == 6'd59) &&
             (ds_q == 4'd9) && (cs_q == 4'd9) && (ms_q == 4'd9);

    if (clear) begin
      state_next   = IDLE;
      presc_next   = '0;
      hours_next   = '0;
      minutes_next = '0;
      seconds_next = '0;
      ds_next      = '0;
      cs_next      = '0;
      ms_next      = '0;
    end else begin
      unique case (state)
        IDLE, PAUSED: begin
          // stop outranks start even where stop itself has no effect
          if (start && !stop) state_next = RUNNING;
        end
        RUNNING: begin
          if (tick) begin
            presc_next = '0;
            if (at_max) begin
              state_next = SATURATED;
            end else begin
              if (stop) state_next = PAUSED;
              // all carries resolve on this one edge
              ms_next = (ms_q == 4'd9) ? 4'd0 : ms_q + 4'd1;
              if (ms_q == 4'd9) begin
                cs_next = (cs_q == 4'd9) ? 4'd0 : cs_q + 4'd1;
                if (cs_q == 4'd9) begin
                  ds_next = (ds_q == 4'd9) ? 4'd0 : ds_q + 4'd1;
                  if (ds_q == 4'd9) begin
                    seconds_next = (seconds_q == 6'd59) ? 6'd0 : seconds_q + 6'd1;
                    if (seconds_q == 6'd59) begin
                      minutes_next = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
                      if (minutes_q == 6'd59) hours_next = hours_q + 5'd1;
                    end
                  end
                end
              end
            end
          end else begin
            presc_next = presc + 1'b1;
            if (stop) state_next = PAUSED;
          end
        end
        SATURATED: state_next = SATURATED;
        default:   state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      presc     <= '0;
      hours_q   <= '0;
      minutes_q <= '0;
      seconds_q <= '0;
      ds_q      <= '0;
      cs_q      <= '0;
      ms_q      <= '0;
      running   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_next;
      presc     <= presc_next;
      hours_q   <= hours_next;
      minutes_q <= minutes_next;
      seconds_q <= seconds_next;
      ds_q      <= ds_next;
      cs_q      <= cs_next;
      ms_q      <= ms_next;
      running   <= (state_next == RUNNING);
      overflow  <= (state_next == SATURATED);
    end
  end

`ifdef TIMER_VBLANK_SYNC_EN
  // Shadows capture the live counters only during blanking so digits never change mid-frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      time_hours        <= '0;
      time_minutes      <= '0;
      time_seconds      <= '0;
      time_deciseconds  <= '0;
      time_centiseconds <= '0;
      time_milliseconds <= '0;
    end else if (vblank) begin
      time_hours        <= hours_q;
      time_minutes      <= minutes_q;
      time_seconds      <= seconds_q;
      time_deciseconds  <= ds_q;
      time_centiseconds <= cs_q;
      time_milliseconds <= ms_q;
    end
  end
`else
  assign time_hours        = hours_q;
  assign time_minutes      = minutes_q;
  assign time_seconds      = seconds_q;
  assign time_deciseconds  = ds_q;
  assign time_centiseconds = cs_q;
  assign time_milliseconds = ms_q;
`endif

endmodule
